// File: rtl/alu_result_stage.sv
// Output stage behind adder_substractor: a 2-entry FIFO that narrows 32-bit results to 16 bits
// and attaches zero/negative/overflow flags. It also keeps a saturating count of overflow events.
module alu_result_stage #(
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_mode,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);

    typedef struct packed {
        logic [15:0] data;
        logic        mode;
        logic        zero;
        logic        neg;
        logic        ovf;
    } entry_t;

    entry_t     mem [2];
    entry_t     new_entry;
    entry_t     head;
    logic [1:0] count;
    logic       wptr;
    logic       rptr;
    logic       push;
    logic       pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The result fits in 16 signed bits only when bits 31..15 are all copies of the sign.
    always_comb begin
        new_entry      = '0;
        new_entry.ovf  = ~((&in_result[31:15]) | ~(|in_result[31:15]));
        new_entry.mode = in_mode;
        if (SATURATE && new_entry.ovf) begin
            new_entry.data = in_result[31] ? 16'h8000 : 16'h7FFF;
        end else begin
            new_entry.data = in_result[15:0];
        end
        new_entry.zero = (new_entry.data == 16'h0000);
        new_entry.neg  = new_entry.data[15];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= new_entry;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // A clear wins over a simultaneous overflow push; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= '0;
        end else if (push && new_entry.ovf && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

    assign head     = mem[rptr];
    assign out_data = head.data;
    assign out_mode = head.mode;
    assign out_zero = head.zero;
    assign out_neg  = head.neg;
    assign out_ovf  = head.ovf;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench: runs a saturating and a wrapping build side by side.
// Both builds are checked against a queue-based reference model, constant vectors and corner sequences.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_result = '0;
    logic        in_mode = 1'b0;
    logic        out_ready = 1'b0;
    logic        ovf_clr = 1'b0;

    logic        in_ready_s, out_valid_s, out_mode_s, out_zero_s, out_neg_s, out_ovf_s;
    logic [15:0] out_data_s;
    logic [7:0]  ovf_count_s;
    logic        in_ready_w, out_valid_w, out_mode_w, out_zero_w, out_neg_w, out_ovf_w;
    logic [15:0] out_data_w;
    logic [7:0]  ovf_count_w;

    int checks = 0;
    int errors = 0;

    int  q_res[$];
    bit  q_mode[$];
    int  exp_cnt = 0;
    bit  last_push = 1'b0;

    always #5 clk = ~clk;

    alu_result_stage #(.SATURATE(1'b1), .CNT_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_result(in_result), .in_mode(in_mode), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_mode(out_mode_s),
        .out_zero(out_zero_s), .out_neg(out_neg_s), .out_ovf(out_ovf_s),
        .ovf_count(ovf_count_s), .ovf_clr(ovf_clr)
    );

    alu_result_stage #(.SATURATE(1'b0), .CNT_W(8)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_result(in_result), .in_mode(in_mode), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .out_mode(out_mode_w),
        .out_zero(out_zero_w), .out_neg(out_neg_w), .out_ovf(out_ovf_w),
        .ovf_count(ovf_count_w), .ovf_clr(ovf_clr)
    );

    function automatic bit ref_ovf(int r);
        return (r > 32767) || (r < -32768);
    endfunction

    function automatic int ref_data(int r, bit sat);
        longint m;
        if (sat && ref_ovf(r)) return (r > 0) ? 32767 + 0 : 32768;
        m = ((longint'(r) % 65536) + 65536) % 65536;
        return int'(m);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(bit v, int r, bit m, bit rdy, bit clr);
        in_valid  = v;
        in_result = r;
        in_mode   = m;
        out_ready = rdy;
        ovf_clr   = clr;
    endtask

    // Advance one clock and update the model with whatever the inputs made happen at that edge.
    task automatic tick();
        bit push, pop, ovf;
        push = in_valid && (q_res.size() < 2);
        pop  = out_ready && (q_res.size() > 0);
        ovf  = push && ref_ovf(int'(in_result));
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q_res.pop_front());
            void'(q_mode.pop_front());
        end
        if (push) begin
            q_res.push_back(int'(in_result));
            q_mode.push_back(in_mode);
        end
        if (ovf_clr) exp_cnt = 0;
        else if (ovf && exp_cnt < 255) exp_cnt++;
        last_push = push;
    endtask

    task automatic checkOutput(string tag);
        int d_s, d_w;
        chk({tag, ".in_ready_s"}, in_ready_s, q_res.size() < 2);
        chk({tag, ".in_ready_w"}, in_ready_w, q_res.size() < 2);
        chk({tag, ".out_valid_s"}, out_valid_s, q_res.size() > 0);
        chk({tag, ".out_valid_w"}, out_valid_w, q_res.size() > 0);
        chk({tag, ".ovf_count_s"}, ovf_count_s, exp_cnt);
        chk({tag, ".ovf_count_w"}, ovf_count_w, exp_cnt);
        if (q_res.size() > 0) begin
            d_s = ref_data(q_res[0], 1'b1);
            d_w = ref_data(q_res[0], 1'b0);
            chk({tag, ".data_s"}, out_data_s, d_s);
            chk({tag, ".data_w"}, out_data_w, d_w);
            chk({tag, ".mode_s"}, out_mode_s, q_mode[0]);
            chk({tag, ".mode_w"}, out_mode_w, q_mode[0]);
            chk({tag, ".zero_s"}, out_zero_s, d_s == 0);
            chk({tag, ".zero_w"}, out_zero_w, d_w == 0);
            chk({tag, ".neg_s"}, out_neg_s, d_s >= 32768);
            chk({tag, ".neg_w"}, out_neg_w, d_w >= 32768);
            chk({tag, ".ovf_s"}, out_ovf_s, ref_ovf(q_res[0]));
            chk({tag, ".ovf_w"}, out_ovf_w, ref_ovf(q_res[0]));
        end
    endtask

    task automatic checkZeroed(string tag);
        chk({tag, ".valid"}, {out_valid_s, out_valid_w}, 2'b00);
        chk({tag, ".ready"}, {in_ready_s, in_ready_w}, 2'b11);
        chk({tag, ".data"}, {out_data_s, out_data_w}, 32'h0);
        chk({tag, ".flags"}, {out_mode_s, out_zero_s, out_neg_s, out_ovf_s,
                              out_mode_w, out_zero_w, out_neg_w, out_ovf_w}, 8'h00);
        chk({tag, ".cnt"}, {ovf_count_s, ovf_count_w}, 16'h0);
    endtask

    typedef struct {
        int          res;
        bit          mode;
        logic [15:0] d_sat;
        logic [15:0] d_wrap;
        bit          z_sat;
        bit          z_wrap;
        bit          n_sat;
        bit          n_wrap;
        bit          ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int r;
        bit v, m, rdy, clr;

        vecs[0] = '{70,          1'b0, 16'h0046, 16'h0046, 0, 0, 0, 0, 0};
        vecs[1] = '{40000,       1'b0, 16'h7FFF, 16'h9C40, 0, 0, 0, 1, 1};
        vecs[2] = '{-40000,      1'b1, 16'h8000, 16'h63C0, 0, 0, 1, 0, 1};
        vecs[3] = '{32'h00010000, 1'b0, 16'h7FFF, 16'h0000, 0, 1, 0, 0, 1};
        vecs[4] = '{0,           1'b1, 16'h0000, 16'h0000, 1, 1, 0, 0, 0};
        vecs[5] = '{-1,          1'b0, 16'hFFFF, 16'hFFFF, 0, 0, 1, 1, 0};
        vecs[6] = '{32767,       1'b1, 16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 0};
        vecs[7] = '{-32768,      1'b0, 16'h8000, 16'h8000, 0, 0, 1, 1, 0};
        vecs[8] = '{32768,       1'b1, 16'h7FFF, 16'h8000, 0, 0, 0, 1, 1};
        vecs[9] = '{-32769,      1'b0, 16'h8000, 16'h7FFF, 0, 0, 1, 0, 1};

        #3;
        checkZeroed("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, vecs[i].res, vecs[i].mode, 1'b1, 1'b0);
            tick();
            checkOutput("vec_model");
            chk($sformatf("vec%0d.valid", i), {out_valid_s, out_valid_w}, 2'b11);
            chk($sformatf("vec%0d.data_s", i), out_data_s, vecs[i].d_sat);
            chk($sformatf("vec%0d.data_w", i), out_data_w, vecs[i].d_wrap);
            chk($sformatf("vec%0d.zn", i), {out_zero_s, out_zero_w, out_neg_s, out_neg_w},
                {vecs[i].z_sat, vecs[i].z_wrap, vecs[i].n_sat, vecs[i].n_wrap});
            chk($sformatf("vec%0d.ovf", i), {out_ovf_s, out_ovf_w}, {vecs[i].ovf, vecs[i].ovf});
            chk($sformatf("vec%0d.mode", i), {out_mode_s, out_mode_w}, {vecs[i].mode, vecs[i].mode});
            applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
            tick();
            checkOutput("vec_drain");
        end
        chk("vec.ovf_count", ovf_count_s, 8'd5);

        // Backpressure: 30 stays presented while the FIFO is full, then drains in order.
        applyStimulus(1'b1, 10, 1'b0, 1'b0, 1'b0); tick(); checkOutput("bp_push10");
        applyStimulus(1'b1, 20, 1'b1, 1'b0, 1'b0); tick(); checkOutput("bp_push20");
        chk("bp.in_ready_full", in_ready_s, 1'b0);
        applyStimulus(1'b1, 30, 1'b0, 1'b0, 1'b0); tick(); checkOutput("bp_hold30");
        chk("bp.head10", out_data_s, 16'd10);
        applyStimulus(1'b1, 30, 1'b0, 1'b1, 1'b0); tick(); checkOutput("bp_pop10");
        chk("bp.head20", out_data_s, 16'd20);
        tick(); checkOutput("bp_pushpop");
        chk("bp.head30", out_data_w, 16'd30);
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0); tick(); checkOutput("bp_drain");
        chk("bp.empty", {out_valid_s, in_ready_s}, 2'b01);

        // Saturation of the overflow counter, then clear colliding with an overflow push.
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1); tick(); checkOutput("cnt_clr");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 100000 + i, 1'b0, 1'b1, 1'b0);
            tick();
        end
        checkOutput("cnt_sat");
        chk("cnt.sat255", ovf_count_w, 8'd255);
        applyStimulus(1'b1, -70000, 1'b1, 1'b1, 1'b1); tick(); checkOutput("cnt_clr_push");
        chk("cnt.clr_wins", ovf_count_s, 8'd0);
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0); tick(); checkOutput("cnt_drain");

        // Randomised traffic; a refused request is held until accepted.
        v = 0; r = 0; m = 0;
        for (int i = 0; i < 400; i++) begin
            if (!v || last_push) begin
                v = ($urandom_range(0, 3) != 0);
                m = $urandom_range(0, 1);
                case ($urandom_range(0, 3))
                    0: r = int'($urandom_range(0, 200)) - 100;
                    1: r = 32767 + int'($urandom_range(0, 4)) - 2;
                    2: r = int'($urandom);
                    default: r = -32768 + int'($urandom_range(0, 4)) - 2;
                endcase
            end
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 31) == 0);
            applyStimulus(v, r, m, rdy, clr);
            tick();
            checkOutput("rand");
        end

        // Asynchronous reset with two entries queued.
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0); tick(); tick();
        applyStimulus(1'b1, 111, 1'b0, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 40000, 1'b1, 1'b0, 1'b0); tick(); checkOutput("rst_pre");
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkZeroed("rst_async");
        q_res.delete();
        q_mode.delete();
        exp_cnt = 0;
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 5, 1'b0, 1'b1, 1'b0); tick(); checkOutput("rst_push5");
        chk("rst.data5", {out_valid_s, out_data_s}, {1'b1, 16'd5});
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0); tick(); checkOutput("rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
